// File: rtl/tl_uh_mem_responder_pkg.sv
// Shared widths, TileLink-UH opcodes and the queued request record for the memory responder.
package tl_uh_mem_responder_pkg;

  localparam int unsigned SIZE_WD   = 3;
  localparam int unsigned ADDR_WD   = 36;
  localparam int unsigned DATA_WD   = 256;
  localparam int unsigned SOURCE_WD = 32;
  localparam int unsigned SINK_WD   = 32;
  localparam int unsigned ECHO_WD   = 32;
  localparam int unsigned MASK_WD   = DATA_WD / 8;
  localparam int unsigned OFF       = 5;
  localparam int unsigned MEM_AW    = 8;
  localparam int unsigned MEM_DEPTH = 1 << MEM_AW;
  localparam int unsigned QDEPTH    = 4;
  localparam int unsigned BEAT_WD   = 3;

  localparam logic [2:0] PUT_FULL        = 3'd0;
  localparam logic [2:0] PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] GET             = 3'd4;
  localparam logic [2:0] ACCESS_ACK      = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

  // Request record; the address is kept as the starting beat index into memory.
  typedef struct packed {
    logic [2:0]           opcode;
    logic [SIZE_WD-1:0]   size;
    logic [SOURCE_WD-1:0] source;
    logic [ECHO_WD-1:0]   echo;
    logic [MEM_AW-1:0]    word;
    logic                 denied;
  } req_t;

  function automatic logic [BEAT_WD-1:0] beats(input logic [SIZE_WD-1:0] size);
    if (size <= SIZE_WD'(OFF)) return BEAT_WD'(1);
    return BEAT_WD'(1) << (size - SIZE_WD'(OFF));
  endfunction

endpackage

// File: rtl/tl_uh_mem_responder_fifo.sv
// Synchronous request FIFO; a pop frees its slot before a same-cycle push lands.
module tl_uh_mem_responder_fifo
  import tl_uh_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH = QDEPTH
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  req_t push_data,
  input  logic pop,
  output req_t head_c,
  output logic full,
  output logic empty
);

  localparam int unsigned PTR_WD = $clog2(DEPTH);
  localparam int unsigned CNT_WD = PTR_WD + 1;

  req_t              store [DEPTH];
  logic [PTR_WD-1:0] wr_ptr, rd_ptr;
  logic [CNT_WD-1:0] count, count_nxt;
  logic              do_push, do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head_c  = store[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop)      count_nxt = count + CNT_WD'(1);
    else if (!do_push && do_pop) count_nxt = count - CNT_WD'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_WD'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_WD'(1);
      count <= count_nxt;
      full  <= (count_nxt == CNT_WD'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) store[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/tl_uh_mem_responder.sv
// TileLink-UH manager-side responder: Get/PutFull/PutPartial against an internal beat memory.
module tl_uh_mem_responder
  import tl_uh_mem_responder_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic [2:0]           a_opcode,
  input  logic [2:0]           a_param,
  input  logic [SIZE_WD-1:0]   a_size,
  input  logic [SOURCE_WD-1:0] a_source,
  input  logic [ADDR_WD-1:0]   a_address,
  input  logic [ECHO_WD-1:0]   a_echo,
  input  logic [MASK_WD-1:0]   a_mask,
  input  logic [DATA_WD-1:0]   a_data,
  input  logic                 a_corrupt,
  input  logic                 a_valid,
  output logic                 a_ready,
  output logic [2:0]           d_opcode,
  output logic [1:0]           d_param,
  output logic [SIZE_WD-1:0]   d_size,
  output logic [SOURCE_WD-1:0] d_source,
  output logic [SINK_WD-1:0]   d_sink,
  output logic                 d_denied,
  output logic [ECHO_WD-1:0]   d_echo,
  output logic [DATA_WD-1:0]   d_data,
  output logic                 d_corrupt,
  output logic                 d_valid,
  input  logic                 d_ready
);

  localparam int unsigned GP_WD = $clog2(QDEPTH + 2);

  typedef enum logic {A_IDLE, A_PUT_BURST} a_state_t;
  typedef enum logic {D_IDLE, D_BURST} d_state_t;

  logic [DATA_WD-1:0] mem [MEM_DEPTH];

  a_state_t           a_state;
  logic [BEAT_WD-1:0] a_beat;
  req_t               a_req, req_now;
  logic               op_is_put, op_legal, misaligned, out_of_range, first_denied;
  logic               a_is_put_now, a_last, a_fire, mem_we;
  logic [MEM_AW-1:0]  wr_word;

  d_state_t           d_state;
  logic [BEAT_WD-1:0] d_beat, src_beat;
  req_t               d_req, src, q_head;
  logic               src_is_get, src_last, d_last, d_load, have_beat;
  logic [MEM_AW-1:0]  src_word;

  logic               q_push, q_pop, q_full, q_empty;
  logic [GP_WD-1:0]   gets_pending;
  logic               gp_inc, gp_dec;
  logic               unused_ok;

  assign unused_ok = ^a_param;

  // First-beat classification of the A request.
  assign op_is_put    = (a_opcode == PUT_FULL) || (a_opcode == PUT_PARTIAL);
  assign op_legal     = op_is_put || (a_opcode == GET);
  assign misaligned   = (a_address & ((ADDR_WD'(1) << a_size) - ADDR_WD'(1))) != '0;
  assign out_of_range = (a_address >> (MEM_AW + OFF)) != '0;
  assign first_denied = !op_legal || misaligned || out_of_range;

  // Request fields come from the bus on the first beat and from the latch mid-burst.
  always_comb begin
    req_now      = a_req;
    a_is_put_now = 1'b1;
    if (a_state == A_IDLE) begin
      req_now.opcode = a_opcode;
      req_now.size   = a_size;
      req_now.source = a_source;
      req_now.echo   = a_echo;
      req_now.word   = a_address[MEM_AW+OFF-1:OFF];
      req_now.denied = first_denied;
      a_is_put_now   = op_is_put;
    end
  end

  assign a_last  = !a_is_put_now || (a_beat == beats(req_now.size) - BEAT_WD'(1));
  assign a_ready = reset && ((a_state == A_PUT_BURST) ||
                             (!q_full && !(op_is_put && gets_pending != '0)));
  assign a_fire  = a_valid && a_ready;
  assign q_push  = a_fire && a_last;
  assign wr_word = req_now.word + MEM_AW'(a_beat);
  assign mem_we  = a_fire && a_is_put_now && !req_now.denied && !a_corrupt;

  always_ff @(posedge clock) begin
    if (!reset) begin
      a_state <= A_IDLE;
      a_beat  <= '0;
      a_req   <= '0;
    end else if (a_fire) begin
      if (a_last) begin
        a_state <= A_IDLE;
        a_beat  <= '0;
      end else begin
        a_state <= A_PUT_BURST;
        a_beat  <= a_beat + BEAT_WD'(1);
        if (a_state == A_IDLE) a_req <= req_now;
      end
    end
  end

  // Byte-masked Put beat write; memory is deliberately left untouched by reset.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int b = 0; b < int'(MASK_WD); b++) begin
        if (a_mask[b]) mem[wr_word][b*8 +: 8] <= a_data[b*8 +: 8];
      end
    end
  end

  tl_uh_mem_responder_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (q_push),
    .push_data (req_now),
    .pop       (q_pop),
    .head_c    (q_head),
    .full      (q_full),
    .empty     (q_empty)
  );

  // Gets queued or still on D; holds off Puts that could overwrite unreturned data.
  assign gp_inc = q_push && (req_now.opcode == GET);
  assign gp_dec = d_valid && d_ready && d_last && (d_opcode == ACCESS_ACK_DATA);

  always_ff @(posedge clock) begin
    if (!reset)               gets_pending <= '0;
    else if (gp_inc && !gp_dec) gets_pending <= gets_pending + GP_WD'(1);
    else if (!gp_inc && gp_dec) gets_pending <= gets_pending - GP_WD'(1);
  end

  // Next D beat source: queue head when idle, the current burst otherwise.
  always_comb begin
    src      = d_req;
    src_beat = d_beat;
    if (d_state == D_IDLE) begin
      src      = q_head;
      src_beat = '0;
    end
    src_is_get = (src.opcode == GET);
    src_word   = src.word + MEM_AW'(src_beat);
    src_last   = !src_is_get || (src_beat == beats(src.size) - BEAT_WD'(1));
  end

  assign d_load    = !d_valid || d_ready;
  assign have_beat = (d_state == D_BURST) || !q_empty;
  assign q_pop     = d_load && (d_state == D_IDLE) && !q_empty;
  assign d_param   = '0;
  assign d_sink    = '0;

  always_ff @(posedge clock) begin
    if (!reset) begin
      d_state   <= D_IDLE;
      d_beat    <= '0;
      d_req     <= '0;
      d_last    <= 1'b0;
      d_valid   <= 1'b0;
      d_opcode  <= '0;
      d_size    <= '0;
      d_source  <= '0;
      d_echo    <= '0;
      d_denied  <= 1'b0;
      d_corrupt <= 1'b0;
      d_data    <= '0;
    end else if (d_load) begin
      if (have_beat) begin
        d_valid   <= 1'b1;
        d_opcode  <= src_is_get ? ACCESS_ACK_DATA : ACCESS_ACK;
        d_size    <= src.size;
        d_source  <= src.source;
        d_echo    <= src.echo;
        d_denied  <= src.denied;
        d_corrupt <= src.denied && src_is_get;
        d_data    <= (src_is_get && !src.denied) ? mem[src_word] : '0;
        d_last    <= src_last;
        if (d_state == D_IDLE) d_req <= q_head;
        if (src_last) begin
          d_state <= D_IDLE;
          d_beat  <= '0;
        end else begin
          d_state <= D_BURST;
          d_beat  <= src_beat + BEAT_WD'(1);
        end
      end else begin
        d_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tl_uh_mem_responder.sv
// Scoreboard bench for tl_uh_mem_responder: expected D beats queued at A fire, checked on D fire.
module tb_tl_uh_mem_responder;

  typedef struct packed {
    logic [2:0]   op;
    logic         denied;
    logic         corrupt;
    logic [2:0]   size;
    logic [31:0]  source;
    logic [31:0]  echo;
    logic [255:0] data;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [2:0]   a_opcode = '0, a_param = '0, a_size = '0;
  logic [31:0]  a_source = '0, a_echo = '0, a_mask = '0;
  logic [35:0]  a_address = '0;
  logic [255:0] a_data = '0;
  logic         a_corrupt = 1'b0, a_valid = 1'b0, d_ready = 1'b1;
  logic         a_ready, d_denied, d_corrupt, d_valid;
  logic [2:0]   d_opcode, d_size;
  logic [1:0]   d_param;
  logic [31:0]  d_source, d_sink, d_echo;
  logic [255:0] d_data;

  int           tests = 0;
  int           fails = 0;
  exp_t         sb[$];
  logic [255:0] model [256];
  bit           held = 0;
  logic [327:0] saved;

  always #5 clock = ~clock;

  tl_uh_mem_responder dut (
    .clock(clock), .reset(reset),
    .a_opcode(a_opcode), .a_param(a_param), .a_size(a_size), .a_source(a_source),
    .a_address(a_address), .a_echo(a_echo), .a_mask(a_mask), .a_data(a_data),
    .a_corrupt(a_corrupt), .a_valid(a_valid), .a_ready(a_ready),
    .d_opcode(d_opcode), .d_param(d_param), .d_size(d_size), .d_source(d_source),
    .d_sink(d_sink), .d_denied(d_denied), .d_echo(d_echo), .d_data(d_data),
    .d_corrupt(d_corrupt), .d_valid(d_valid), .d_ready(d_ready)
  );

  function automatic logic [255:0] pat(input int seed);
    logic [255:0] v;
    for (int i = 0; i < 8; i++)
      v[i*32 +: 32] = 32'(seed) * 32'h01000193 + 32'(i) * 32'h00010001 + 32'h5A5A0000;
    return v;
  endfunction

  function automatic bit bench_denied(input logic [2:0] op, input logic [2:0] size,
                                      input logic [35:0] addr);
    longint unsigned a = 64'(addr);
    longint unsigned bytes = 64'd1 << size;
    return !(op == 3'd0 || op == 3'd1 || op == 3'd4) || (a % bytes != 0) || (a >= 64'h2000);
  endfunction

  function automatic int nbeats(input logic [2:0] size);
    return (size <= 3'd5) ? 1 : (1 << (size - 3'd5));
  endfunction

  // D-side scoreboard consumer plus hold-stability check while stalled.
  always @(negedge clock) begin
    exp_t e;
    if (!reset) held = 0;
    else if (d_valid) begin
      if (held) begin
        tests++;
        if ({d_opcode, d_denied, d_corrupt, d_size, d_source, d_echo, d_data} !== saved) begin
          fails++;
          $display("FAIL d_stable: beat changed while stalled, got data=%h need %h",
                   d_data, saved[255:0]);
        end
      end
      if (d_ready) begin
        held = 0;
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL d_unexpected: got op=%0d data=%h, need no beat", d_opcode, d_data);
        end else begin
          e = sb.pop_front();
          if ({d_opcode, d_denied, d_corrupt, d_size, d_source, d_echo, d_param, d_sink} !==
              {e.op, e.denied, e.corrupt, e.size, e.source, e.echo, 2'b0, 32'b0} ||
              d_data !== e.data) begin
            fails++;
            $display("FAIL d_beat: got op=%0d den=%0b cor=%0b size=%0d src=%h data=%h, need op=%0d den=%0b cor=%0b size=%0d src=%h data=%h",
                     d_opcode, d_denied, d_corrupt, d_size, d_source, d_data,
                     e.op, e.denied, e.corrupt, e.size, e.source, e.data);
          end
        end
      end else begin
        held = 1;
        saved = {d_opcode, d_denied, d_corrupt, d_size, d_source, d_echo, d_data};
      end
    end
  end

  task automatic send_beat(input logic [2:0] op, input logic [2:0] size, input logic [35:0] addr,
                           input logic [31:0] mask, input logic [255:0] data,
                           input logic [31:0] src, input int budget, output bit ok);
    a_opcode = op; a_size = size; a_address = addr; a_mask = mask; a_data = data;
    a_source = src; a_echo = ~src; a_corrupt = 1'b0; a_valid = 1'b1;
    ok = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clock);
      if (a_ready) begin
        @(posedge clock); #1;
        ok = 1;
        break;
      end
    end
  endtask

  task automatic push_get_exp(input logic [2:0] op, input logic [2:0] size,
                              input logic [35:0] addr, input logic [31:0] src);
    exp_t e;
    bit den = bench_denied(op, size, addr);
    logic [7:0] w = addr[12:5];
    int n = (op == 3'd4) ? nbeats(size) : 1;
    for (int b = 0; b < n; b++) begin
      e.op = (op == 3'd4) ? 3'd1 : 3'd0;
      e.denied = den;
      e.corrupt = den && (op == 3'd4);
      e.size = size; e.source = src; e.echo = ~src;
      e.data = (op == 3'd4 && !den) ? model[w + 8'(b)] : '0;
      sb.push_back(e);
    end
  endtask

  task automatic do_get(input logic [2:0] op, input logic [2:0] size, input logic [35:0] addr,
                        input logic [31:0] src);
    bit ok;
    send_beat(op, size, addr, '1, '0, src, 200, ok);
    a_valid = 1'b0;
    if (!ok) begin
      tests++; fails++;
      $display("FAIL a_accept_get: a_ready stayed 0, need 1");
      @(posedge clock); #1;
      return;
    end
    push_get_exp(op, size, addr, src);
  endtask

  task automatic do_put(input logic [2:0] op, input logic [2:0] size, input logic [35:0] addr,
                        input logic [31:0] mask, input logic [255:0] d0, input int nsend,
                        input logic [31:0] src);
    bit ok;
    exp_t e;
    bit den = bench_denied(op, size, addr);
    logic [7:0] w = addr[12:5];
    logic [255:0] dat;
    for (int b = 0; b < nsend; b++) begin
      dat = d0 + 256'(b);
      send_beat(op, size, addr, mask, dat, src, 200, ok);
      if (!ok) begin
        a_valid = 1'b0;
        tests++; fails++;
        $display("FAIL a_accept_put: a_ready stayed 0 at beat %0d, need 1", b);
        @(posedge clock); #1;
        return;
      end
      if (!den)
        for (int k = 0; k < 32; k++)
          if (mask[k]) model[w + 8'(b)][k*8 +: 8] = dat[k*8 +: 8];
    end
    a_valid = 1'b0;
    if (nsend == nbeats(size)) begin
      e.op = 3'd0; e.denied = den; e.corrupt = 1'b0; e.size = size;
      e.source = src; e.echo = ~src; e.data = '0;
      sb.push_back(e);
    end
  endtask

  task automatic wait_drain(input int budget);
    for (int c = 0; c < budget && sb.size() != 0; c++) begin
      @(posedge clock); #1;
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d beats still outstanding, need 0", sb.size());
      sb.delete();
    end
    repeat (3) begin @(posedge clock); #1; end
  endtask

  task automatic test_reset();
    reset = 1'b0; d_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    tests++;
    if ({a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_echo, d_corrupt} !== '0) begin
      fails++;
      $display("FAIL reset_ctrl: got a_ready=%0b d_valid=%0b d_opcode=%0d, need all 0", a_ready, d_valid, d_opcode);
    end
    tests++;
    if (d_data !== '0) begin
      fails++;
      $display("FAIL reset_data: got %h, need 0", d_data);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    tests++;
    if (a_ready !== 1'b1) begin
      fails++;
      $display("FAIL idle_ready: got %0b, need 1", a_ready);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_put_get();
    do_put(3'd0, 3'd5, 36'h40, '1, pat(1), 1, 32'h11);
    wait_drain(50);
    do_get(3'd4, 3'd5, 36'h40, 32'hCAFE0001);
    wait_drain(50);
  endtask

  task automatic test_partial();
    logic [255:0] d;
    d = {{7{32'h12345678}}, 32'hAABBCCDD};
    do_put(3'd0, 3'd5, 36'h0, '1, '0, 1, 32'h21);
    do_put(3'd1, 3'd5, 36'h0, 32'h0000000F, d, 1, 32'h22);
    do_get(3'd4, 3'd5, 36'h0, 32'h23);
    wait_drain(50);
  endtask

  task automatic test_burst();
    do_put(3'd0, 3'd7, 36'h80, '1, pat(40), 4, 32'h31);
    wait_drain(50);
    do_get(3'd4, 3'd7, 36'h80, 32'h32);
    for (int c = 0; c < 60 && sb.size() != 0; c++) begin
      d_ready = (c % 2 == 0);
      @(posedge clock); #1;
    end
    d_ready = 1'b1;
    wait_drain(20);
  endtask

  task automatic test_denied();
    do_get(3'd4, 3'd5, 36'h2000, 32'h41);
    do_get(3'd2, 3'd5, 36'h40, 32'h42);
    do_get(3'd4, 3'd6, 36'h20, 32'h43);
    wait_drain(80);
    do_put(3'd0, 3'd5, 36'h41, '1, pat(99), 1, 32'h44);
    wait_drain(50);
    do_get(3'd4, 3'd5, 36'h40, 32'h45);
    wait_drain(50);
  endtask

  task automatic test_back_to_back();
    bit ok;
    int accepted = 0;
    d_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send_beat(3'd4, 3'd5, 36'h40, '1, '0, 32'h50 + 32'(i), 6, ok);
      if (!ok) break;
      accepted++;
      push_get_exp(3'd4, 3'd5, 36'h40, 32'h50 + 32'(i));
    end
    a_valid = 1'b0;
    @(posedge clock); #1;
    tests++;
    if (accepted != 5) begin
      fails++;
      $display("FAIL gets_accepted: got %0d, need 5", accepted);
    end
    send_beat(3'd0, 3'd5, 36'h60, '1, pat(7), 32'h5F, 4, ok);
    tests++;
    if (ok) begin
      fails++;
      $display("FAIL put_blocked: put accepted with gets pending, need stall");
    end
    d_ready = 1'b1;
    do_put(3'd0, 3'd5, 36'h60, '1, pat(7), 1, 32'h5F);
    tests++;
    if (sb.size() != 1) begin
      fails++;
      $display("FAIL put_order: %0d beats queued at put fire, need 1", sb.size());
    end
    wait_drain(100);
    do_get(3'd4, 3'd5, 36'h60, 32'h60);
    wait_drain(50);
  endtask

  task automatic test_reset_mid_burst();
    do_put(3'd0, 3'd7, 36'h100, '1, pat(200), 4, 32'h71);
    wait_drain(50);
    do_put(3'd0, 3'd7, 36'h100, '1, pat(300), 2, 32'h72);
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    tests++;
    if ({a_ready, d_valid, d_denied, d_corrupt, d_opcode} !== '0 || d_data !== '0) begin
      fails++;
      $display("FAIL mid_reset: got a_ready=%0b d_valid=%0b data=%h, need 0", a_ready, d_valid, d_data);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (4) begin @(posedge clock); #1; end
    do_get(3'd4, 3'd7, 36'h100, 32'h73);
    wait_drain(60);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_put_get();
    test_partial();
    test_burst();
    test_denied();
    test_back_to_back();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
